game_menu_ctrl: RTL and testbench

//  Pre-game menu controller: selects board size with top/bottom buttons, starts the game on a mouse-left click, and returns to menu on game_over.

---
 rtl/game_pkg.sv | 26 ++
 rtl/menu_btn_repeat.sv | 82 ++++++++
 rtl/game_menu_ctrl.sv | 132 +++++++++++++
 tb/tb_game_menu_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the pre-game menu controller.
//   menu_state_t : top-level controller states
//   Def*         : default board-size range and button timing
//   cnt_width()  : width of the lockout/repeat counter for a given timing
package game_pkg;

  typedef enum logic [1:0] {
    MENU,
    GAME,
    RELEASE
  } menu_state_t;

  localparam int unsigned DefMinSize      = 2;
  localparam int unsigned DefMaxSize      = 5;
  localparam int unsigned DefDefaultSize  = 2;
  localparam int unsigned DefHoldDelay    = 40_000_000;
  localparam int unsigned DefRepeatCycles = 10_000_000;

  // Enough bits to hold the larger of the two reload values.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned rep);
    int unsigned m;
    m = (hold > rep) ? hold : rep;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/menu_btn_repeat.sv
// Edge detect, bounce lockout and auto-repeat for the top/bottom size buttons.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   en                : high only while the menu accepts steps; low clears counter and repeat
//   top, bottom       : raw button levels (top = decrement, bottom = increment)
//   step_inc/step_dec : one-cycle step strobes (combinational, registered by the caller)
module menu_btn_repeat
  import game_pkg::*;
#(
  parameter int unsigned HOLD_DELAY    = DefHoldDelay,
  parameter int unsigned REPEAT_CYCLES = DefRepeatCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic top,
  input  logic bottom,
  output logic step_inc,
  output logic step_dec
);

  localparam int unsigned CntW = cnt_width(HOLD_DELAY, REPEAT_CYCLES);
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_DELAY - 1);
  localparam logic [CntW-1:0] RepLoad  = CntW'(REPEAT_CYCLES - 1);

  logic            top_q, bottom_q;
  logic            armed_q, armed_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            inc, dec, held, rise, cnt_zero, fire_first, fire_rep;

  always_comb begin
    // Both buttons together means no direction.
    inc        = bottom & ~top;
    dec        = top & ~bottom;
    held       = inc | dec;
    rise       = (inc & ~bottom_q) | (dec & ~top_q);
    cnt_zero   = (cnt_q == '0);
    fire_first = en & rise & cnt_zero;
    // Repeat only while the button has stayed down since a real step; a press that was
    // locked out, or one held through reset, never starts repeating.
    fire_rep   = en & held & ~rise & armed_q & cnt_zero;
    step_inc   = (fire_first | fire_rep) & inc;
    step_dec   = (fire_first | fire_rep) & dec;

    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (!en) begin
      cnt_d   = '0;
      armed_d = 1'b0;
    end else begin
      if (fire_first) begin
        cnt_d = HoldLoad;
      end else if (fire_rep) begin
        cnt_d = RepLoad;
      end else if (!cnt_zero) begin
        cnt_d = cnt_q - CntW'(1);
      end

      if (!held) begin
        armed_d = 1'b0;
      end else if (fire_first || fire_rep) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Previous samples start high so a button held through reset shows no edge.
      top_q    <= 1'b1;
      bottom_q <= 1'b1;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      top_q    <= top;
      bottom_q <= bottom;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/game_menu_ctrl.sv
// Pre-game menu controller: board-size selection, game start on mouse click, return to
// the menu after game_over once all buttons are released.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   top, bottom    : size decrement / increment buttons (levels)
//   mouse_left     : start-game button (level)
//   game_over      : leave the game
//   board_size     : selected board size
//   is_game_on     : high while in GAME
//   start_pulse    : one-cycle pulse on entering GAME
//   size_changed   : one-cycle pulse with each board_size update
module game_menu_ctrl
  import game_pkg::*;
#(
  parameter int unsigned MIN_SIZE      = DefMinSize,
  parameter int unsigned MAX_SIZE      = DefMaxSize,
  parameter int unsigned DEFAULT_SIZE  = DefDefaultSize,
  parameter int unsigned WRAP          = 0,
  parameter int unsigned HOLD_DELAY    = DefHoldDelay,
  parameter int unsigned REPEAT_CYCLES = DefRepeatCycles,
  localparam int unsigned SIZE_W       = $clog2(MAX_SIZE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              top,
  input  logic              bottom,
  input  logic              mouse_left,
  input  logic              game_over,
  output logic [SIZE_W-1:0] board_size,
  output logic              is_game_on,
  output logic              start_pulse,
  output logic              size_changed
);

  // One spare bit so MAX+1 and MIN-1 (even with MIN=0) are both detectable.
  localparam int unsigned ExtW = SIZE_W + 1;
  localparam logic [ExtW-1:0] MinExt = ExtW'(MIN_SIZE);
  localparam logic [ExtW-1:0] MaxExt = ExtW'(MAX_SIZE);

  menu_state_t       state_q, state_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              on_q, on_d;
  logic              start_q, start_d;
  logic              chg_q, chg_d;
  logic              mouse_q;
  logic              mouse_rise, btn_en, step_inc, step_dec;
  logic [ExtW-1:0]   size_ext, size_next;

  assign mouse_rise = mouse_left & ~mouse_q;
  // A click wins over a same-cycle step.
  assign btn_en     = (state_q == MENU) & ~mouse_rise;

  menu_btn_repeat #(
    .HOLD_DELAY    (HOLD_DELAY),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_btn (
    .clk      (clk),
    .rst      (rst),
    .en       (btn_en),
    .top      (top),
    .bottom   (bottom),
    .step_inc (step_inc),
    .step_dec (step_dec)
  );

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    chg_d     = 1'b0;
    size_ext  = {1'b0, size_q};
    size_next = size_ext;
    if (step_inc) begin
      size_next = size_ext + ExtW'(1);
    end else if (step_dec) begin
      size_next = size_ext - ExtW'(1);
    end

    unique case (state_q)
      MENU: begin
        if (mouse_rise) begin
          state_d = GAME;
        end else if (step_inc || step_dec) begin
          if (size_next >= MinExt && size_next <= MaxExt) begin
            size_d = size_next[SIZE_W-1:0];
            chg_d  = 1'b1;
          end else if (WRAP != 0) begin
            size_d = step_inc ? SIZE_W'(MIN_SIZE) : SIZE_W'(MAX_SIZE);
            chg_d  = 1'b1;
          end
        end
      end
      GAME: begin
        if (game_over) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!(top || bottom || mouse_left)) begin
          state_d = MENU;
        end
      end
      default: state_d = MENU;
    endcase

    on_d    = (state_d == GAME);
    start_d = (state_q == MENU) && (state_d == GAME);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MENU;
      size_q  <= SIZE_W'(DEFAULT_SIZE);
      on_q    <= 1'b0;
      start_q <= 1'b0;
      chg_q   <= 1'b0;
      mouse_q <= 1'b1;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      on_q    <= on_d;
      start_q <= start_d;
      chg_q   <= chg_d;
      mouse_q <= mouse_left;
    end
  end

  assign board_size   = size_q;
  assign is_game_on   = on_q;
  assign start_pulse  = start_q;
  assign size_changed = chg_q;

endmodule

// File: tb/tb_game_menu_ctrl.sv
// Scoreboard bench for game_menu_ctrl: each driven cycle pushes the hand-derived outputs
// expected after the next clock edge; a monitor pops and compares them after that edge.
module tb_game_menu_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       top, bottom, mouse_left, game_over;
  logic       w_top, w_bottom, w_mouse_left, w_game_over;
  logic [2:0] board_size, w_board_size;
  logic       is_game_on, start_pulse, size_changed;
  logic       w_is_game_on, w_start_pulse, w_size_changed;

  always #5 clk = ~clk;

  game_menu_ctrl #(
    .MIN_SIZE(2), .MAX_SIZE(5), .DEFAULT_SIZE(2), .WRAP(0), .HOLD_DELAY(4), .REPEAT_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .top(top), .bottom(bottom), .mouse_left(mouse_left),
    .game_over(game_over), .board_size(board_size), .is_game_on(is_game_on),
    .start_pulse(start_pulse), .size_changed(size_changed)
  );

  game_menu_ctrl #(
    .MIN_SIZE(2), .MAX_SIZE(5), .DEFAULT_SIZE(2), .WRAP(1), .HOLD_DELAY(4), .REPEAT_CYCLES(2)
  ) dut_w (
    .clk(clk), .rst(rst), .top(w_top), .bottom(w_bottom), .mouse_left(w_mouse_left),
    .game_over(w_game_over), .board_size(w_board_size), .is_game_on(w_is_game_on),
    .start_pulse(w_start_pulse), .size_changed(w_size_changed)
  );

  typedef struct {
    bit wrap;
    bit peek;
    int size;
    bit on;
    bit start;
    bit chg;
    int id;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_failed = 0;
  int   seq = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs (to dut, or dut_w when w=1) and queue the expected outputs.
  task automatic cyc(input bit w, input bit r, input bit t, input bit b, input bit m,
                     input bit g, input int size, input bit on, input bit st, input bit ch,
                     input bit peek = 1'b0);
    exp_t e;
    @(negedge clk);
    rst = r;
    if (w) begin
      w_top = t; w_bottom = b; w_mouse_left = m; w_game_over = g;
    end else begin
      top = t; bottom = b; mouse_left = m; game_over = g;
    end
    e.wrap = w; e.peek = peek; e.size = size; e.on = on; e.start = st; e.chg = ch;
    e.id = seq;
    seq++;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.wrap) begin
          check($sformatf("c%0d.w.size", e.id), 32'(w_board_size), e.size);
          check($sformatf("c%0d.w.on", e.id), 32'(w_is_game_on), 32'(e.on));
          check($sformatf("c%0d.w.start", e.id), 32'(w_start_pulse), 32'(e.start));
          check($sformatf("c%0d.w.chg", e.id), 32'(w_size_changed), 32'(e.chg));
        end else begin
          check($sformatf("c%0d.size", e.id), 32'(board_size), e.size);
          check($sformatf("c%0d.on", e.id), 32'(is_game_on), 32'(e.on));
          check($sformatf("c%0d.start", e.id), 32'(start_pulse), 32'(e.start));
          check($sformatf("c%0d.chg", e.id), 32'(size_changed), 32'(e.chg));
        end
        if (e.peek) begin
          check($sformatf("c%0d.state", e.id), 32'(dut.state_q), 32'(MENU));
          check($sformatf("c%0d.cnt", e.id), 32'(dut.u_btn.cnt_q), 32'd0);
        end
      end
    end
  end

  initial begin : stim
    int t2_size[12];
    bit t2_chg[12];
    t2_size = '{3, 3, 3, 3, 4, 4, 5, 5, 5, 5, 5, 5};
    t2_chg  = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};

    rst = 1'b1; top = 1'b0; bottom = 1'b1; mouse_left = 1'b0; game_over = 1'b0;
    w_top = 1'b0; w_bottom = 1'b0; w_mouse_left = 1'b0; w_game_over = 1'b0;

    // 1: bottom held through reset gives no step; a fresh press steps once
    cyc(0, 1, 0, 1, 0, 0, 2, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 2, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 3, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 3, 0, 0, 0);

    // 2: held bottom from size 2: hold delay, then repeats, saturating at 5
    cyc(0, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 0, 0, t2_size[i], 0, 0, t2_chg[i]);
    cyc(0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 4, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 4, 0, 0, 0);

    // 3: wrap instance: 2 -> 5 on top, re-press inside lockout ignored, 5 -> 2 on bottom
    cyc(1, 0, 1, 0, 0, 0, 5, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 5, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 2, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 2, 0, 0, 0);

    // 4: click and bottom together start the game without a step; buttons ignored in GAME
    cyc(0, 0, 0, 1, 1, 0, 4, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0, 4, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 4, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 4, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 4, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 4, 1, 0, 0);

    // 5: game_over with click held waits for release; next click restarts at same size
    cyc(0, 0, 0, 0, 1, 1, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 4, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 4, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 4, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 4, 0, 0, 0);

    // 6: reset during an active lockout with top held
    cyc(0, 0, 1, 0, 0, 0, 3, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 0, 3, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 2, 0, 0, 0, 1'b1);
    cyc(0, 0, 1, 0, 0, 0, 2, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 2, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 2, 0, 0, 0);

    repeat (3) @(posedge clk);
    #5;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
